// File: rtl/apb_rr_master_if.sv
// APB bus bundle between the round-robin master and its slave.
interface apb_rr_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NREQ requesters onto one APB bus,
// returns read data/error to the owner, aborts hung transfers on timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | bus idle; grant the round-robin winner if any request
// S_SETUP  | APB setup phase, psel=1 penable=0, one cycle
// S_ACCESS | APB access phase, wait for pready or timeout
module apb_rr_master #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   prst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  apb_rr_master_if.master        apb
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_last_grant;
  logic [IDX_W-1:0]  r_owner;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic              w_timeout;
  logic [ADDR_W-1:0] w_addr_arr  [NREQ];
  logic [DATA_W-1:0] w_wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin : p_arb
    logic [IDX_W-1:0] v_cand;
    w_found = 1'b0;
    w_win   = '0;
    v_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      v_cand = IDX_W'((int'(r_last_grant) + k) % NREQ);
      if (!w_found && req_valid[v_cand]) begin
        w_found = 1'b1;
        w_win   = v_cand;
      end
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_state == S_ACCESS) && !apb.pready &&
                     (r_wait_cnt == TO_LAST);

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (apb.pready || w_timeout) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: if (w_found) req_ready[w_win] = 1'b1;
      S_SETUP: begin
        apb.psel = 1'b1;
        busy     = 1'b1;
      end
      S_ACCESS: begin
        apb.psel    = 1'b1;
        apb.penable = 1'b1;
        busy        = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      r_last_grant <= IDX_W'(NREQ - 1);
      r_owner      <= '0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_owner      <= w_win;
          r_last_grant <= w_win;
          r_pwrite     <= req_write[w_win];
          r_paddr      <= w_addr_arr[w_win];
          r_pwdata     <= w_wdata_arr[w_win];
          r_wait_cnt   <= '0;
        end
        S_ACCESS: begin
          if (apb.pready) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_rdata          <= r_pwrite ? '0 : apb.prdata;
            r_rsp_err            <= apb.pslverr;
          end else if (w_timeout) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_rdata          <= '0;
            r_rsp_err            <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign apb.pwrite = r_pwrite;
  assign apb.paddr  = r_paddr;
  assign apb.pwdata = r_pwdata;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: zero/wait-state transfers, fairness,
// slave error, timeout abort and asynchronous reset mid-transfer.
module tb_apb_rr_master;
  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_write = '0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  int          n_total = 0;
  int          n_bad   = 0;

  apb_rr_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_rr_master #(.NREQ(4), .ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk      (pclk),
    .prst      (prst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .apb       (bus.master)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transfer from a single requester; wait states show garbage prdata/pslverr.
  task automatic xfer(input int who, input bit wr, input logic [7:0] addr,
                      input logic [7:0] wdata, input int waits, input logic [7:0] rd,
                      input bit serr, input logic [7:0] exp_rd, input bit exp_err);
    @(negedge pclk);
    req_valid = 4'(1 << who);
    req_write[who] = wr;
    req_addr[who*8 +: 8] = addr;
    req_wdata[who*8 +: 8] = wdata;
    bus.pready = 1'b0;
    #1 chk("grant", req_ready, 32'(1 << who));
    @(negedge pclk);
    req_valid = '0;
    #1 chk("setup_ctl", {bus.psel, bus.penable, busy}, 3'b101);
    chk("setup_addr", {bus.pwrite, bus.paddr, bus.pwdata}, {wr, addr, wdata});
    for (int i = 0; i < waits; i++) begin
      @(negedge pclk);
      bus.pready = 1'b0; bus.prdata = 8'hEE; bus.pslverr = 1'b1;
      #1 chk("wait_ctl", {bus.psel, bus.penable, rsp_valid}, 6'b110000);
      chk("wait_addr", bus.paddr, addr);
    end
    @(negedge pclk);
    bus.pready = 1'b1; bus.prdata = rd; bus.pslverr = serr;
    #1 chk("access_ctl", {bus.psel, bus.penable, rsp_valid}, 6'b110000);
    chk("access_addr", bus.paddr, addr);
    @(negedge pclk);
    bus.pready = 1'b0; bus.pslverr = 1'b0;
    #1 chk("rsp_valid", rsp_valid, 32'(1 << who));
    chk("rsp_data", {rsp_err, rsp_rdata}, {exp_err, exp_rd});
    chk("rsp_idle", {bus.psel, bus.penable, busy}, 3'b000);
  endtask

  initial begin
    logic [3:0] order [6];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001; order[5] = 4'b0010;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;

    #12;
    chk("rst_ctl", {bus.psel, bus.penable, bus.pwrite, busy}, 4'b0000);
    chk("rst_bus", {bus.paddr, bus.pwdata}, 16'h0000);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 13'h0);
    @(negedge pclk);
    prst = 1'b1;

    xfer(0, 1'b1, 8'h12, 8'hA5, 0, 8'h77, 1'b0, 8'h00, 1'b0);
    xfer(2, 1'b0, 8'h40, 8'h00, 2, 8'h3C, 1'b0, 8'h3C, 1'b0);
    xfer(1, 1'b1, 8'h33, 8'h5A, 0, 8'h66, 1'b1, 8'h00, 1'b1);
    xfer(3, 1'b0, 8'h7F, 8'h00, 1, 8'h81, 1'b0, 8'h81, 1'b0);

    // Fairness with all requesters pending and zero-wait slave.
    req_addr  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_write = 4'b0000;
    for (int g = 0; g < 6; g++) begin
      @(negedge pclk);
      if (g == 0) begin
        req_valid = 4'hF; bus.pready = 1'b1; bus.prdata = 8'h55;
      end
      #1 chk("rr_grant", req_ready, order[g]);
      if (g > 0) chk("rr_rsp", rsp_valid, order[g-1]);
      @(negedge pclk);
      @(negedge pclk);
      #1 chk("rr_addr", bus.paddr, 8'h10 + 8'(g % 4));
    end
    @(negedge pclk);
    req_valid = '0; bus.pready = 1'b0;
    #1 chk("rr_last_rsp", rsp_valid, 4'b0010);

    // Timeout: req2 hangs, req3 waits and is granted on the abort cycle.
    @(negedge pclk);
    req_valid = 4'b1100; req_write = 4'b0000;
    req_addr[16 +: 8] = 8'hA2; req_addr[24 +: 8] = 8'hA3;
    #1 chk("to_grant", req_ready, 4'b0100);
    @(negedge pclk);
    req_valid = 4'b1000;
    #1 chk("to_setup", {bus.psel, bus.penable, bus.paddr}, {2'b10, 8'hA2});
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      #1 chk("to_access", {bus.psel, bus.penable, rsp_valid, bus.paddr}, {2'b11, 4'b0000, 8'hA2});
    end
    @(negedge pclk);
    #1 chk("to_rsp", {rsp_valid, rsp_err, rsp_rdata}, {4'b0100, 1'b1, 8'h00});
    chk("to_bus", {bus.psel, bus.penable}, 2'b00);
    chk("to_next_grant", req_ready, 4'b1000);
    @(negedge pclk);
    req_valid = '0;
    #1 chk("to_next_setup", {bus.psel, bus.paddr}, {1'b1, 8'hA3});
    @(negedge pclk);
    bus.pready = 1'b1; bus.prdata = 8'h99; bus.pslverr = 1'b0;
    @(negedge pclk);
    bus.pready = 1'b0;
    #1 chk("to_next_rsp", {rsp_valid, rsp_err, rsp_rdata}, {4'b1000, 1'b0, 8'h99});

    // Asynchronous reset in the middle of ACCESS.
    @(negedge pclk);
    req_valid = 4'b0001; req_addr[7:0] = 8'h5E;
    #1 chk("rs_grant", req_ready, 4'b0001);
    @(negedge pclk);
    req_valid = '0;
    @(negedge pclk);
    #1 chk("rs_access", {bus.psel, bus.penable}, 2'b11);
    #1 prst = 1'b0;
    #1 chk("rs_drop", {bus.psel, bus.penable, busy, rsp_valid}, 7'b0);
    chk("rs_bus", {bus.paddr, bus.pwdata, rsp_rdata}, 24'h0);
    req_valid = 4'b1001;
    @(negedge pclk);
    chk("rs_no_rsp", {rsp_valid, bus.psel}, 5'b0);
    prst = 1'b1;
    #1 chk("rs_first", req_ready, 4'b0001);
    @(negedge pclk);
    req_valid = '0;
    #1 chk("rs_setup", {bus.psel, bus.penable, rsp_valid, bus.paddr}, {2'b10, 4'b0000, 8'h5E});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master that shares one APB bus (pclk/prst, psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr) among NREQ local requesters. The block accepts one request at a time through a valid/ready handshake and runs the APB SETUP and ACCESS phases, honouring slave wait states. It returns read data and error status to the owning requester and aborts hung transfers with a timeout. It sits between the bus-using blocks and the APB slave interface.

## Interface

- NREQ, 4: number of requesters, 2..8.
- ADDR_W, 8: APB address width.
- DATA_W, 8: APB data width.
- TIMEOUT, 16: number of consecutive pready-low ACCESS cycles before abort; 0 disables the timeout.

- pclk  in  1  clock; all logic is on the rising edge.
- prst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_write  in  NREQ  1 = write, 0 = read, per requester.
- req_addr  in  NREQ*ADDR_W  requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  one-hot grant (combinational); a request transfers on the edge where req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  one-hot, 1-cycle completion pulse to the owner.
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborts; holds until the next response.
- rsp_err  out  1  pslverr or timeout; valid with rsp_valid.
- busy  out  1  high in SETUP and ACCESS.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  slave ready; wait states are allowed.
- pslverr  in  1  slave error, sampled with pready.

## Operation

- FSM states: IDLE, SETUP, ACCESS.
- IDLE
  - psel=0, penable=0.
  - If any req_valid is high, req_ready is asserted for exactly one winner.
  - Round-robin search starts at (last_grant+1) mod NREQ.
  - On the edge: latch the winner's write/addr/wdata into pwrite/paddr/pwdata, record owner, set last_grant=owner, go to SETUP.
- SETUP: psel=1, penable=0 for one cycle, then go to ACCESS.
- ACCESS
  - psel=1, penable=1.
  - On an edge with pready=1:
    - Capture rsp_rdata = pwrite ? 0 : prdata.
    - rsp_err = pslverr.
    - Pulse rsp_valid[owner] in the next cycle.
    - Go to IDLE.
  - Wait counter increments on each ACCESS edge with pready=0.
  - If TIMEOUT != 0 and the count reaches TIMEOUT:
    - Abort: go to IDLE.
    - rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0.
- pwrite, paddr and pwdata are stable from SETUP through the end of ACCESS, and hold their last values in IDLE.
- req_ready is all-zero outside IDLE. Requests remain pending; there is no queueing.
- In IDLE, a grant is allowed in the same cycle rsp_valid is high.
- Reset values:
  - State IDLE.
  - psel, penable, pwrite = 0; paddr, pwdata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - last_grant = NREQ-1, so requester 0 wins first.
  - Wait counter = 0.
- Reset mid-transfer: all outputs go to reset values immediately (asynchronous). The in-flight transfer is dropped with no rsp_valid.

## Timing

- Accept edge t0 (IDLE cycle, req_ready high).
- SETUP in cycle t0+1, ACCESS starts in cycle t0+2.
- Zero wait: rsp_valid in cycle t0+3. Minimum 3 cycles per transfer; at most one transfer per 3 cycles.
- Each pready-low ACCESS cycle adds 1 cycle of latency.
- Timeout: ACCESS lasts TIMEOUT cycles; rsp_valid is in the cycle after the last one.
- The wait counter is wide enough to hold TIMEOUT and is cleared on entry to SETUP.
- pslverr and prdata are ignored unless pready=1 in ACCESS.

## Test plan

- Write, zero wait: req0 write addr 0x12 data 0xA5, pready=1 -> psel at t0+1, penable at t0+2, paddr=0x12, pwdata=0xA5, rsp_valid=0001 at t0+3, rsp_err=0.
- Read, 2 wait states: req2 read 0x40, pready low for 2 ACCESS cycles, prdata=0x3C -> ACCESS lasts 3 cycles, rsp_valid=0100, rsp_rdata=0x3C, paddr stable throughout.
- Fairness: all four req_valid held high -> grant order 0,1,2,3,0,1; each requester gets one grant per 12 cycles.
- Slave error: write with pready=1, pslverr=1 -> rsp_err=1, rsp_rdata=0; the next transfer shows rsp_err=0.
- Timeout: TIMEOUT=16, pready held at 0 -> ACCESS for 16 cycles, then psel=0, rsp_err=1, rsp_rdata=0; the next requester is granted.
- Reset mid-ACCESS: drop prst -> psel/penable go to 0 immediately, no rsp_valid; after release with req0 and req3 valid, req0 is granted first.
